noise_adder: RTL and testbench
==============================

// Module: noise_adder
// PURPOSE
//  Channel-noise stage of the spread-spectrum transmit chain. Sits after the
//  chip coder and runs at the chip clock (clk31, 31 chips per data bit).
//  Adds pseudo-random integer noise to each 2-bit signed chip symbol and
//  emits a registered 3-bit signed noisy sample for the receiver.
// PARAMETERS
//  LFSR_SEED  15'h0001  initial noise-LFSR state; 0 is replaced by 15'h0001
//  NOISE_LVL  2         0 = no noise, 1 = noise in {-1,0,+1}, 2 = noise in {-2..+1}
// PORTS
//  clk31           in   1  chip clock, single clock domain, rising edge
//  rst_n           in   1  asynchronous active-low reset
//  un_noised_data  in   2  chip symbol, 2's complement (01=+1, 11=-1, 00=idle, 10=-2)
//  noised_data     out  3  noisy sample, 2's complement, registered
// BEHAVIOUR
//  - Single clock (clk31); async active-low reset (rst_n).
//  - Reset (rst_n=0, asynchronous): noised_data=3'b000; lfsr=LFSR_SEED (or 1 if 0).
//  - Noise LFSR: 15-bit Fibonacci, x^15+x^14+1, advances every clk31 edge
//    out of reset: lfsr <= {lfsr[13:0], lfsr[14]^lfsr[13]}; period 32767.
//  - Noise value n uses lfsr BEFORE the shift of the same edge, from lfsr[1:0]:
//    NOISE_LVL=2: n = signed(lfsr[1:0]) -> 00:0, 01:+1, 10:-2, 11:-1
//    NOISE_LVL=1: 00:0, 01:+1, 10:-1, 11:0
//    NOISE_LVL=0: n=0 (LFSR still runs; pure 1-cycle-delayed passthrough)
//  - Arithmetic: noised_data <= sext3(un_noised_data) + sext3(n).
//    Sum range -4..+2 always fits 3-bit signed; no saturation, no wrap.
//  - Latency: exactly 1 clk31 cycle from input sample to output.
//  - No handshake: every cycle is a valid sample; idle input 00 still gets noise.
//  - Reset mid-operation: output clears immediately, LFSR reloads, and the
//    noise sequence restarts from the seed on the first edge after release.
//  - Input is sampled on the rising edge and must be stable around that edge.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream -> noised_data=000 at once; after
//    release with seed 1, the noise sequence replays identically.
//  2 NOISE_LVL=0: inputs 01,11,00,10 -> outputs 001,111,000,110, each one
//    cycle later.
//  3 NOISE_LVL=2, seed 1, input held 01: edges 1..15 give 010,111, then 001 x12,
//    then 010 (lfsr = 1<<k for k=0..13, then 0x4001).
//  4 Extremes, NOISE_LVL=2: input 10 with n=-2 -> 100 (-4); input 11 with n=-2
//    -> 101 (-3); input 01 with n=+1 -> 010 (+2).
//  5 LFSR period: from seed 1, state returns to 15'h0001 after exactly 32767
//    edges and never reaches 0.
//  6 NOISE_LVL=1, seed 1, input 11: first two outputs 000 (n=+1), 110 (n=-1).

Source files
------------

// File: rtl/noise_adder.sv
// Channel-noise stage of the spread-spectrum transmit chain. A 15-bit LFSR
// produces a small signed noise term every chip clock. The term is added to
// the signed 2-bit chip symbol, and the 3-bit sum is registered with
// one-cycle latency.
module noise_adder #(
  parameter logic [14:0] LFSR_SEED = 15'h0001,
  parameter int unsigned NOISE_LVL = 2
) (
  input  logic       clk31,
  input  logic       rst_n,
  input  logic [1:0] un_noised_data,
  output logic [2:0] noised_data
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1
  localparam logic [14:0] SeedEff = (LFSR_SEED == 15'd0) ? 15'h0001 : LFSR_SEED;

  logic [14:0] lfsr_q, lfsr_d;
  logic [2:0]  noise;
  logic [2:0]  out_q, out_d;

  // Fibonacci step for x^15 + x^14 + 1
  always_comb begin
    lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
  end

  // Map the pre-shift LFSR bits [1:0] to a sign-extended noise term
  always_comb begin
    noise = 3'b000;
    if (NOISE_LVL == 32'd2) begin
      noise = {lfsr_q[1], lfsr_q[1:0]};
    end else if (NOISE_LVL == 32'd1) begin
      unique case (lfsr_q[1:0])
        2'b01:   noise = 3'b001;
        2'b10:   noise = 3'b111;
        default: noise = 3'b000;
      endcase
    end
  end

  // The sum spans -4..+2, so the 3-bit result never overflows
  always_comb begin
    out_d = {un_noised_data[1], un_noised_data} + noise;
  end

  // The LFSR and the output register share the asynchronous reset
  always_ff @(posedge clk31 or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SeedEff;
      out_q  <= 3'b000;
    end else begin
      lfsr_q <= lfsr_d;
      out_q  <= out_d;
    end
  end

  assign noised_data = out_q;

endmodule

// File: tb/tb_noise_adder.sv
module tb_noise_adder;

  logic       clk31 = 1'b0;
  logic       rst_n;
  logic [1:0] d0, d1, d2;
  logic [2:0] q0, q1, q2;

  always #5 clk31 = ~clk31;

  noise_adder #(.LFSR_SEED(15'h0001), .NOISE_LVL(0)) u_lvl0 (
    .clk31(clk31), .rst_n(rst_n), .un_noised_data(d0), .noised_data(q0));
  noise_adder #(.LFSR_SEED(15'h0001), .NOISE_LVL(1)) u_lvl1 (
    .clk31(clk31), .rst_n(rst_n), .un_noised_data(d1), .noised_data(q1));
  noise_adder #(.LFSR_SEED(15'h0001), .NOISE_LVL(2)) u_lvl2 (
    .clk31(clk31), .rst_n(rst_n), .un_noised_data(d2), .noised_data(q2));

  typedef struct {
    logic [2:0] e0;
    logic [2:0] e1;
    logic [2:0] e2;
    string      name;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [14:0] m_lfsr;
  bit          due = 1'b0;
  logic [2:0]  t3[15];

  function automatic logic [2:0] model_out(logic [1:0] d, logic [14:0] l, int lvl);
    logic [2:0] n;
    n = 3'b000;
    if (lvl == 2) begin
      n = {l[1], l[1:0]};
    end else if (lvl == 1) begin
      case (l[1:0])
        2'b01:   n = 3'b001;
        2'b10:   n = 3'b111;
        default: n = 3'b000;
      endcase
    end
    return {d[1], d} + n;
  endfunction

  task automatic check(string name, logic [2:0] got, logic [2:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Monitor: an entry is due once the edge that samples its inputs has passed
  always @(posedge clk31) due = rst_n && (sb.size() != 0);

  always @(negedge clk31) begin : monitor
    exp_t e;
    if (due) begin
      e = sb.pop_front();
      check({e.name, " lvl0"}, q0, e.e0);
      check({e.name, " lvl1"}, q1, e.e1);
      check({e.name, " lvl2"}, q2, e.e2);
    end
  end

  // Apply one sample to all lanes, push expectations, step the noise model
  task automatic drive(logic [1:0] a0, logic [1:0] a1, logic [1:0] a2,
                       logic [2:0] h0, logic [2:0] h1, logic [2:0] h2,
                       logic [2:0] use_h, string name);
    exp_t e;
    d0 = a0;
    d1 = a1;
    d2 = a2;
    e.e0 = use_h[0] ? h0 : model_out(a0, m_lfsr, 0);
    e.e1 = use_h[1] ? h1 : model_out(a1, m_lfsr, 1);
    e.e2 = use_h[2] ? h2 : model_out(a2, m_lfsr, 2);
    e.name = name;
    sb.push_back(e);
    m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
    @(posedge clk31);
    #2;
  endtask

  // Assert reset between edges, check the immediate clear, release after 2 edges
  task automatic do_reset(string name);
    @(negedge clk31);
    #1;
    rst_n = 1'b0;
    #1;
    check({name, " rst lvl0"}, q0, 3'b000);
    check({name, " rst lvl1"}, q1, 3'b000);
    check({name, " rst lvl2"}, q2, 3'b000);
    @(posedge clk31);
    @(posedge clk31);
    #2;
    rst_n  = 1'b1;
    m_lfsr = 15'h0001;
  endtask

  initial begin
    logic [1:0]  l0_in[4];
    logic [2:0]  l0_ex[4];
    logic [2:0]  l1_ex[2];
    logic [14:0] lf;
    int          first_ret;
    int          hit_zero;

    l0_in = '{2'b01, 2'b11, 2'b00, 2'b10};
    l0_ex = '{3'b001, 3'b111, 3'b000, 3'b110};
    l1_ex = '{3'b000, 3'b110};
    for (int i = 0; i < 15; i++)
      t3[i] = (i == 0 || i == 14) ? 3'b010 : (i == 1) ? 3'b111 : 3'b001;

    d0 = 2'b00;
    d1 = 2'b00;
    d2 = 2'b00;
    rst_n = 1'b0;
    #1;
    check("power-on rst lvl0", q0, 3'b000);
    check("power-on rst lvl1", q1, 3'b000);
    check("power-on rst lvl2", q2, 3'b000);
    @(posedge clk31);
    @(posedge clk31);
    #2;
    rst_n  = 1'b1;
    m_lfsr = 15'h0001;

    // Seed-1 sequence: passthrough, held +1 with level-2 noise, level-1 on -1
    for (int i = 0; i < 15; i++)
      drive(l0_in[i % 4], (i < 2) ? 2'b11 : 2'b01, 2'b01,
            l0_ex[i % 4], l1_ex[i % 2], t3[i],
            {1'b1, i < 2, i < 4}, $sformatf("seq c%0d", i + 1));

    for (int i = 0; i < 10; i++)
      drive(2'(i), 2'(i + 1), 2'(i + 2), 3'b000, 3'b000, 3'b000, 3'b000,
            $sformatf("free c%0d", i));

    // Mid-stream reset: the noise sequence must replay from the seed
    do_reset("mid");
    for (int i = 0; i < 15; i++)
      drive(2'b01, (i == 0) ? 2'b11 : 2'b10, 2'b01,
            3'b001, (i == 0) ? 3'b000 : 3'b101, t3[i],
            {1'b1, i < 2, 1'b1}, $sformatf("replay c%0d", i + 1));

    // Extremes: first edge uses n=+1, second edge n=-2 (level 2) / -1 (level 1)
    do_reset("ext1");
    drive(2'b10, 2'b01, 2'b00, 3'b110, 3'b010, 3'b001, 3'b111, "ext1 c1");
    drive(2'b10, 2'b10, 2'b10, 3'b110, 3'b101, 3'b100, 3'b111, "ext1 c2");
    do_reset("ext2");
    drive(2'b11, 2'b10, 2'b10, 3'b111, 3'b111, 3'b111, 3'b111, "ext2 c1");
    drive(2'b01, 2'b00, 2'b11, 3'b001, 3'b111, 3'b101, 3'b111, "ext2 c2");

    // Full period with idle input on level 2, so its output exposes the noise
    do_reset("period");
    first_ret = 0;
    hit_zero  = 0;
    for (int k = 1; k <= 32767 + 8; k++) begin
      drive(~2'(k), 2'(k), 2'b00, 3'b000, 3'b000, 3'b000, 3'b000, "period");
      lf = u_lvl2.lfsr_q;
      if (lf == 15'd0) hit_zero = 1;
      if (lf == 15'h0001 && first_ret == 0) first_ret = k;
    end
    check_int("period length", first_ret, 32767);
    check_int("lfsr zero state", hit_zero, 0);

    @(negedge clk31);
    @(negedge clk31);
    check_int("scoreboard drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
